// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary operand encoder.
// Holds the sequencing state enum, the default operand ceiling and the
// small integer helpers used to clamp operands and size the beat counter.
package unary_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } stateT;

   localparam int unsigned DEFAULT_MAX_VAL = 8;

   // Saturate a binary operand to the largest value the unary stream may carry.
   function automatic int unsigned clampToMax(input int unsigned value, input int unsigned maxVal);
      return (value > maxVal) ? maxVal : value;
   endfunction

   function automatic int unsigned maxOf(input int unsigned x, input int unsigned y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/unary_sat_down_counter.sv
// Saturating down counter for one operand of the unary encoder.
// Clamps the binary operand on load, decrements by one per enabled beat and
// parks at zero, so the owner can read "bits still to emit" directly.
module unary_sat_down_counter
   import unary_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MAX_VAL = DEFAULT_MAX_VAL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] value_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] clampedVal_o,
   output logic             clamped_o,
   output logic [WIDTH-1:0] cnt_o,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // The clamped view of the incoming operand is offered combinationally so the
   // owner can decide its first beat and the sticky saturation flag in the same
   // cycle the operand is accepted.
   always_comb begin
      clampedVal_o = WIDTH'(clampToMax(32'(value_i), MAX_VAL));
      clamped_o    = (32'(value_i) > MAX_VAL);
   end

   // Load wins over decrement; a decrement at zero is dropped so the count
   // never wraps back to the top of its range.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = clampedVal_o;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   // Count register, cleared immediately by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/unary_operand_encoder.sv
// Upstream feeder for the unary adder stage.
// Accepts two binary operands, serialises them as unary bursts on A/B and
// steps the adder through load, settle and drain phases before pulsing done.
// Every output is a register whose next value is decided from the next state,
// so a beat computed at a clock edge is the one the adder sees in the
// following cycle.
module unary_operand_encoder
   import unary_pkg::*;
#(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned MAX_VAL       = DEFAULT_MAX_VAL,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned DRAIN_CYCLES  = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_val,
   input  logic [WIDTH-1:0] b_val,
   input  logic             stall,
   output logic             A,
   output logic             B,
   output logic             en,
   output logic             read_or_write,
   output logic             busy,
   output logic             sat,
   output logic             done
);

   // One beat counter times every phase, so it must hold the longest of them.
   localparam int unsigned BEAT_MAX = maxOf(maxOf(MAX_VAL, DRAIN_CYCLES), SETTLE_CYCLES);
   localparam int unsigned BEAT_W   = $clog2(BEAT_MAX + 1);

   localparam logic [BEAT_W-1:0] BEAT_ONE    = BEAT_W'(1);
   localparam logic [BEAT_W-1:0] SETTLE_LOAD = BEAT_W'(SETTLE_CYCLES);
   localparam logic [BEAT_W-1:0] DRAIN_LOAD  = BEAT_W'(DRAIN_CYCLES);

   stateT             state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;

   logic a_q, a_d;
   logic b_q, b_d;
   logic en_q, en_d;
   logic rw_q, rw_d;
   logic busy_q, busy_d;
   logic sat_q, sat_d;
   logic done_q, done_d;

   logic             cntLoad;
   logic             cntDec;
   logic [WIDTH-1:0] clampedA, clampedB;
   logic             clampFlagA, clampFlagB;
   logic [WIDTH-1:0] cntA, cntB;
   logic             zeroA, zeroB;

   unary_sat_down_counter #(
      .WIDTH   (WIDTH),
      .MAX_VAL (MAX_VAL)
   ) counterA (
      .clk          (clk),
      .rst          (rst),
      .load_i       (cntLoad),
      .value_i      (a_val),
      .dec_i        (cntDec),
      .clampedVal_o (clampedA),
      .clamped_o    (clampFlagA),
      .cnt_o        (cntA),
      .zero_o       (zeroA)
   );

   unary_sat_down_counter #(
      .WIDTH   (WIDTH),
      .MAX_VAL (MAX_VAL)
   ) counterB (
      .clk          (clk),
      .rst          (rst),
      .load_i       (cntLoad),
      .value_i      (b_val),
      .dec_i        (cntDec),
      .clampedVal_o (clampedB),
      .clamped_o    (clampFlagB),
      .cnt_o        (cntB),
      .zero_o       (zeroB)
   );

   // Next-state and next-output decision. The operand counters hold the bits
   // still owed including the one on the wire, so the next beat is high only
   // while a counter is above one. A stall freezes state, beat count and
   // operand counters and blanks en/A/B while keeping the phase on
   // read_or_write. The phase lengths assume SETTLE_CYCLES and DRAIN_CYCLES
   // are both at least one.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      cntLoad = 1'b0;
      cntDec  = 1'b0;
      a_d     = 1'b0;
      b_d     = 1'b0;
      en_d    = 1'b0;
      rw_d    = 1'b0;
      done_d  = 1'b0;
      sat_d   = sat_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               cntLoad = 1'b1;
               sat_d   = clampFlagA | clampFlagB;
               en_d    = 1'b1;
               if ((clampedA == '0) && (clampedB == '0)) begin
                  state_d = SETTLE;
                  beat_d  = SETTLE_LOAD;
               end else begin
                  state_d = LOAD;
                  beat_d  = BEAT_W'(maxOf(32'(clampedA), 32'(clampedB)));
                  a_d     = (clampedA != '0);
                  b_d     = (clampedB != '0);
               end
            end
         end

         LOAD: begin
            if (!stall) begin
               cntDec = 1'b1;
               en_d   = 1'b1;
               if (beat_q <= BEAT_ONE) begin
                  state_d = SETTLE;
                  beat_d  = SETTLE_LOAD;
               end else begin
                  beat_d = beat_q - BEAT_ONE;
                  a_d    = !zeroA && (cntA != WIDTH'(1));
                  b_d    = !zeroB && (cntB != WIDTH'(1));
               end
            end
         end

         SETTLE: begin
            if (!stall) begin
               en_d = 1'b1;
               if (beat_q <= BEAT_ONE) begin
                  state_d = DRAIN;
                  beat_d  = DRAIN_LOAD;
                  rw_d    = 1'b1;
               end else begin
                  beat_d = beat_q - BEAT_ONE;
               end
            end
         end

         DRAIN: begin
            rw_d = 1'b1;
            if (!stall) begin
               if (beat_q <= BEAT_ONE) begin
                  state_d = DONE;
                  beat_d  = '0;
                  rw_d    = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  beat_d = beat_q - BEAT_ONE;
                  en_d   = 1'b1;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
            beat_d  = '0;
         end

         default: begin
            state_d = IDLE;
            beat_d  = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State, beat counter and output registers; reset aborts any sequence at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         en_q    <= 1'b0;
         rw_q    <= 1'b0;
         busy_q  <= 1'b0;
         sat_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         a_q     <= a_d;
         b_q     <= b_d;
         en_q    <= en_d;
         rw_q    <= rw_d;
         busy_q  <= busy_d;
         sat_q   <= sat_d;
         done_q  <= done_d;
      end
   end

   assign A             = a_q;
   assign B             = b_q;
   assign en            = en_q;
   assign read_or_write = rw_q;
   assign busy          = busy_q;
   assign sat           = sat_q;
   assign done          = done_q;

endmodule
